// File: rtl/intersection_sensor_if.sv
// intersection_sensor_if: light codes and arrivals in, queue state, sensors and flags out
interface intersection_sensor_if #(parameter int QW = 4, parameter int DW = 8);
  logic          arr_a;
  logic          arr_b;
  logic [1:0]    light_a;
  logic [1:0]    light_b;
  logic [1:0]    t;
  logic [QW-1:0] qcnt_a;
  logic [QW-1:0] qcnt_b;
  logic          drop_a;
  logic          drop_b;
  logic          dep_a;
  logic          dep_b;
  logic [DW-1:0] tot_a;
  logic [DW-1:0] tot_b;
  logic [1:0]    viol;
  modport master (
    output arr_a, arr_b, light_a, light_b,
    input  t, qcnt_a, qcnt_b, drop_a, drop_b, dep_a, dep_b, tot_a, tot_b, viol
  );
  modport slave (
    input  arr_a, arr_b, light_a, light_b,
    output t, qcnt_a, qcnt_b, drop_a, drop_b, dep_a, dep_b, tot_a, tot_b, viol
  );
endinterface

// File: rtl/intersection_sensor.sv
// intersection_sensor: per-street car queues drained on green, sensor feedback and light-code monitor
module intersection_sensor #(
  parameter int QW         = 4,
  parameter int DEPART_CYC = 2,
  parameter int DW         = 8
) (
  input logic                clk,
  input logic                reset,
  intersection_sensor_if.slave s
);
  localparam int TW = DEPART_CYC > 1 ? $clog2(DEPART_CYC) : 1;
  localparam logic [QW-1:0] FULL = '1;
  logic [1:0] arr;
  logic [1:0][1:0] light;
  logic [1:0] viol;
  assign arr   = {s.arr_b, s.arr_a};
  assign light = {s.light_b, s.light_a};
  for (genvar i = 0; i < 2; i++) begin : g_st
    logic [QW-1:0] q;
    logic [TW-1:0] tmr;
    logic [DW-1:0] tot;
    logic          dep;
    logic          drop;
    logic          qual;
    logic          go;
    assign qual = light[i] == 2'b10 && q != '0;
    assign go   = qual && tmr == TW'(DEPART_CYC - 1);
    always_ff @(posedge clk) begin
      if (reset) begin
        q    <= '0;
        tmr  <= '0;
        tot  <= '0;
        dep  <= 1'b0;
        drop <= 1'b0;
      end else begin
        tmr  <= qual && !go ? tmr + TW'(1) : '0;
        dep  <= go;
        drop <= arr[i] && !go && q == FULL;
        q    <= arr[i] && !go ? (q == FULL ? q : q + QW'(1)) : (go && !arr[i] ? q - QW'(1) : q);
        tot  <= go ? tot + DW'(1) : tot;
      end
    end
  end
  // sticky monitor: flags never clear except by reset
  always_ff @(posedge clk) begin
    if (reset) viol <= '0;
    else viol <= viol | {light[0] == 2'b11 || light[1] == 2'b11, light[0] != 2'b00 && light[1] != 2'b00};
  end
  assign s.t      = {g_st[0].q != '0, g_st[1].q != '0};
  assign s.qcnt_a = g_st[0].q;
  assign s.qcnt_b = g_st[1].q;
  assign s.dep_a  = g_st[0].dep;
  assign s.dep_b  = g_st[1].dep;
  assign s.drop_a = g_st[0].drop;
  assign s.drop_b = g_st[1].drop;
  assign s.tot_a  = g_st[0].tot;
  assign s.tot_b  = g_st[1].tot;
  assign s.viol   = viol;
endmodule

// File: tb/tb_intersection_sensor.sv
// tb_intersection_sensor: directed and random stimulus, expected state queued and checked by a monitor
module tb_intersection_sensor;
  localparam int DEP = 2;
  localparam int QMAX = 15;
  typedef struct {
    int t, qa, qb, da, db, xa, xb, ta, tb, v;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  int mq[2], prog[2], mtot[2];
  int mviol;
  intersection_sensor_if #(.QW(4), .DW(8)) bus ();
  intersection_sensor #(.QW(4), .DEPART_CYC(DEP), .DW(8)) dut (.clk(clk), .reset(reset), .s(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // one clock of stimulus; the model advances by the same clock and queues what the DUT must show after it
  task automatic cyc(input bit r, input bit aa, input bit ab, input int la, input int lb);
    exp_t e;
    int arr[2], lt[2], dp[2], dr[2];
    @(negedge clk);
    reset = r; bus.arr_a = aa; bus.arr_b = ab; bus.light_a = 2'(la); bus.light_b = 2'(lb);
    arr[0] = aa; arr[1] = ab; lt[0] = la; lt[1] = lb;
    for (int i = 0; i < 2; i++) begin
      dp[i] = 0; dr[i] = 0;
      if (r) begin
        mq[i] = 0; prog[i] = 0; mtot[i] = 0;
        continue;
      end
      if (lt[i] == 2 && mq[i] > 0) begin
        prog[i]++;
        if (prog[i] == DEP) begin dp[i] = 1; prog[i] = 0; end
      end else prog[i] = 0;
      if (arr[i] && !dp[i]) begin
        if (mq[i] == QMAX) dr[i] = 1; else mq[i]++;
      end else if (dp[i] && !arr[i]) mq[i]--;
      mtot[i] = (mtot[i] + dp[i]) % 256;
    end
    if (r) mviol = 0;
    else begin
      if (la != 0 && lb != 0) mviol |= 1;
      if (la == 3 || lb == 3) mviol |= 2;
    end
    e.t = (mq[0] != 0 ? 2 : 0) + (mq[1] != 0 ? 1 : 0);
    e.qa = mq[0]; e.qb = mq[1]; e.da = dp[0]; e.db = dp[1];
    e.xa = dr[0]; e.xb = dr[1]; e.ta = mtot[0]; e.tb = mtot[1]; e.v = mviol;
    sb.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("t", int'(bus.t), e.t);
        chk("qcnt_a", int'(bus.qcnt_a), e.qa);
        chk("qcnt_b", int'(bus.qcnt_b), e.qb);
        chk("dep_a", int'(bus.dep_a), e.da);
        chk("dep_b", int'(bus.dep_b), e.db);
        chk("drop_a", int'(bus.drop_a), e.xa);
        chk("drop_b", int'(bus.drop_b), e.xb);
        chk("tot_a", int'(bus.tot_a), e.ta);
        chk("tot_b", int'(bus.tot_b), e.tb);
        chk("viol", int'(bus.viol), e.v);
      end
    end
  end
  initial begin
    int la, lb, pa, pb, w;
    bus.arr_a = 0; bus.arr_b = 0; bus.light_a = 0; bus.light_b = 0;
    cyc(1, 0, 0, 0, 2);
    repeat (3) begin cyc(0, 1, 0, 0, 2); cyc(0, 0, 0, 0, 2); end
    repeat (8) cyc(0, 0, 0, 2, 0);
    repeat (16) cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (5) cyc(0, 1, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 2, 0);
    repeat (12) cyc(0, 1, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 2, 0);
    cyc(0, 0, 0, 2, 1);
    repeat (2) cyc(0, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 3);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 2, 0);
    cyc(1, 0, 0, 2, 0);
    repeat (4) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 2, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 2, 0);
    for (int seg = 0; seg < 12; seg++) begin
      pa = $urandom_range(10, 90);
      pb = $urandom_range(10, 90);
      la = 0; lb = 0; w = 0;
      for (int c = 0; c < 200; c++) begin
        if (w == 0) begin
          w = $urandom_range(1, 12);
          case ($urandom_range(0, 9))
            0: begin la = $urandom_range(0, 3); lb = $urandom_range(0, 3); end
            1, 2: begin la = 1; lb = 0; end
            3, 4, 5: begin la = 2; lb = 0; end
            6, 7: begin la = 0; lb = 2; end
            default: begin la = 0; lb = $urandom_range(0, 1); end
          endcase
        end
        w--;
        cyc($urandom_range(0, 499) == 0, $urandom_range(0, 99) < pa, $urandom_range(0, 99) < pb, la, lb);
      end
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
